// File: rtl/prbs64_checker_if.sv
// rtl/prbs64_checker_if.sv - bit stream in / lock status and counters out for the PRBS64 checker
interface prbs64_checker_if #(
    parameter int CNT_W = 32
);
    logic             clear;
    logic             bit_valid;
    logic             bit_in;
    logic             locked;
    logic             err_pulse;
    logic             lock_lost;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output clear, bit_valid, bit_in,
        input  locked, err_pulse, lock_lost, err_count, bit_count
    );

    modport slave (
        input  clear, bit_valid, bit_in,
        output locked, err_pulse, lock_lost, err_count, bit_count
    );
endinterface

// File: rtl/prbs64_checker.sv
// rtl/prbs64_checker.sv - self-synchronising checker for the 64-bit Fibonacci PRBS (taps 0,1,3,4)
module prbs64_checker #(
    parameter int VERIFY_LEN  = 64,
    parameter int WINDOW      = 256,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    prbs64_checker_if.slave    bus
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam int VC_W = $clog2(VERIFY_LEN + 1);
    localparam int WB_W = $clog2(WINDOW + 1);
    localparam int WE_W = $clog2(LOSS_THRESH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nx;
    logic [63:0]      sh, sh_nx;
    logic [6:0]       fill, fill_nx;
    logic [VC_W-1:0]  vcnt, vcnt_nx;
    logic [WB_W-1:0]  win_bits, win_bits_nx;
    logic [WE_W-1:0]  win_err, win_err_nx, win_err_inc;
    logic [CNT_W-1:0] err_cnt, err_cnt_nx, bit_cnt, bit_cnt_nx;
    logic             err_pulse_q, err_pulse_nx;
    logic             lock_lost_q, lock_lost_nx;
    logic             pred, miss;

    // s[0] is the oldest bit; the generator's next output is the XOR of these taps
    assign pred        = sh[0] ^ sh[1] ^ sh[3] ^ sh[4];
    assign miss        = bus.bit_in ^ pred;
    assign win_err_inc = win_err + WE_W'(miss);

    always_comb begin
        state_nx     = state;
        sh_nx        = sh;
        fill_nx      = fill;
        vcnt_nx      = vcnt;
        win_bits_nx  = win_bits;
        win_err_nx   = win_err;
        err_cnt_nx   = err_cnt;
        bit_cnt_nx   = bit_cnt;
        err_pulse_nx = 1'b0;
        lock_lost_nx = 1'b0;
        if (bus.bit_valid) begin
            unique case (state)
                HUNT: begin
                    sh_nx = {bus.bit_in, sh[63:1]};
                    if (fill == 7'd63) begin
                        fill_nx = '0;
                        // an all-zero shadow is the LFSR lock-up state and must never be verified
                        if (sh_nx != '0) begin
                            state_nx = VERIFY;
                            vcnt_nx  = '0;
                        end
                    end else begin
                        fill_nx = fill + 7'd1;
                    end
                end
                VERIFY: begin
                    if (miss) begin
                        err_pulse_nx = 1'b1;
                        state_nx     = HUNT;
                        fill_nx      = '0;
                    end else begin
                        sh_nx = {pred, sh[63:1]};
                        if (vcnt == VC_W'(VERIFY_LEN - 1)) begin
                            state_nx    = LOCKED;
                            win_bits_nx = '0;
                            win_err_nx  = '0;
                        end else begin
                            vcnt_nx = vcnt + VC_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    // free-running on predictions so a line error is counted once, not echoed through the taps
                    sh_nx = {pred, sh[63:1]};
                    if (bit_cnt != CNT_MAX) bit_cnt_nx = bit_cnt + CNT_W'(1);
                    if (miss) begin
                        err_pulse_nx = 1'b1;
                        if (err_cnt != CNT_MAX) err_cnt_nx = err_cnt + CNT_W'(1);
                    end
                    if (miss && (win_err_inc == WE_W'(LOSS_THRESH))) begin
                        state_nx     = HUNT;
                        fill_nx      = '0;
                        lock_lost_nx = 1'b1;
                    end else if (win_bits == WB_W'(WINDOW - 1)) begin
                        win_bits_nx = '0;
                        win_err_nx  = '0;
                    end else begin
                        win_bits_nx = win_bits + WB_W'(1);
                        win_err_nx  = win_err_inc;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
        if (bus.clear) begin
            err_cnt_nx  = '0;
            bit_cnt_nx  = '0;
            win_bits_nx = '0;
            win_err_nx  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            sh          <= '0;
            fill        <= '0;
            vcnt        <= '0;
            win_bits    <= '0;
            win_err     <= '0;
            err_cnt     <= '0;
            bit_cnt     <= '0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state       <= state_nx;
            sh          <= sh_nx;
            fill        <= fill_nx;
            vcnt        <= vcnt_nx;
            win_bits    <= win_bits_nx;
            win_err     <= win_err_nx;
            err_cnt     <= err_cnt_nx;
            bit_cnt     <= bit_cnt_nx;
            err_pulse_q <= err_pulse_nx;
            lock_lost_q <= lock_lost_nx;
        end
    end

    assign bus.locked    = (state == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.err_count = err_cnt;
    assign bus.bit_count = bit_cnt;
endmodule

// File: tb/tb_prbs64_checker.sv
// tb/tb_prbs64_checker.sv - scoreboarded bench for prbs64_checker with scenario table and corner sequences
module tb_prbs64_checker;
    localparam int VL  = 64;
    localparam int WIN = 256;
    localparam int LT  = 8;
    localparam logic [63:0] SEED = 64'h1234_5678_8765_4321;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prbs64_checker_if #(.CNT_W(32)) bus ();
    prbs64_checker_if #(.CNT_W(4))  bus4 ();

    assign bus4.clear     = bus.clear;
    assign bus4.bit_valid = bus.bit_valid;
    assign bus4.bit_in    = bus.bit_in;

    prbs64_checker #(.VERIFY_LEN(VL), .WINDOW(WIN), .LOSS_THRESH(LT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    prbs64_checker #(.VERIFY_LEN(VL), .WINDOW(WIN), .LOSS_THRESH(LT), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    typedef struct packed {
        logic        locked;
        logic        err_pulse;
        logic        lock_lost;
        logic [31:0] ec;
        logic [31:0] bc;
    } exp_t;

    typedef struct {
        string name;
        int    total;
        int    start;
        int    n_per;
        int    gap;
        int    n_periods;
        bit    half;
        bit    zero;
        bit    chk_lock;
        int    exp_err;
        bit    exp_locked;
        int    exp_lost;
    } row_t;

    int n_tests = 0;
    int n_fail  = 0;
    int lost_seen;
    exp_t sb[$];
    logic [63:0] lfsr;

    int          m_st;
    logic [63:0] m_sh;
    int          m_fill, m_v, m_wb, m_we, m_ec, m_bc;
    bit          m_pulse, m_lost;

    function automatic logic gen_bit();
        logic o = lfsr[0];
        lfsr = {lfsr[0] ^ lfsr[1] ^ lfsr[3] ^ lfsr[4], lfsr[63:1]};
        return o;
    endfunction

    function automatic logic [3:0] sat4(input int x);
        return (x > 15) ? 4'hF : 4'(x);
    endfunction

    function automatic logic is_err(input row_t r, input int idx);
        int off;
        if (r.n_per == 0 || idx < r.start || idx >= r.start + r.n_periods * WIN) return 1'b0;
        off = (idx - r.start) % WIN;
        return (off < r.n_per * r.gap) && (off % r.gap == 0);
    endfunction

    task automatic model_reset();
        m_st = 0; m_sh = '0; m_fill = 0; m_v = 0; m_wb = 0; m_we = 0; m_ec = 0; m_bc = 0;
    endtask

    // reference behaviour: 0 = hunting, 1 = verifying, 2 = locked
    task automatic model_step(input logic v, input logic b, input logic clr);
        logic p;
        m_pulse = 0;
        m_lost  = 0;
        if (v) begin
            p = m_sh[0] ^ m_sh[1] ^ m_sh[3] ^ m_sh[4];
            if (m_st == 0) begin
                m_sh = {b, m_sh[63:1]};
                m_fill++;
                if (m_fill == 64) begin
                    m_fill = 0;
                    if (m_sh != 64'd0) begin m_st = 1; m_v = 0; end
                end
            end else if (m_st == 1) begin
                if (b == p) begin
                    m_sh = {p, m_sh[63:1]};
                    m_v++;
                    if (m_v == VL) begin m_st = 2; m_wb = 0; m_we = 0; end
                end else begin
                    m_pulse = 1; m_st = 0; m_fill = 0;
                end
            end else begin
                m_sh = {p, m_sh[63:1]};
                m_bc++;
                m_wb++;
                if (b != p) begin m_pulse = 1; m_ec++; m_we++; end
                if (m_we >= LT) begin
                    m_lost = 1; m_st = 0; m_fill = 0;
                end else if (m_wb == WIN) begin
                    m_wb = 0; m_we = 0;
                end
            end
        end
        if (clr) begin m_ec = 0; m_bc = 0; m_wb = 0; m_we = 0; end
    endtask

    task automatic step(input logic v, input logic b, input logic clr);
        exp_t e, got;
        bus.bit_valid = v;
        bus.bit_in    = b;
        bus.clear     = clr;
        model_step(v, b, clr);
        sb.push_back('{locked: (m_st == 2), err_pulse: m_pulse, lock_lost: m_lost, ec: 32'(m_ec), bc: 32'(m_bc)});
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        got = '{locked: bus.locked, err_pulse: bus.err_pulse, lock_lost: bus.lock_lost,
                ec: bus.err_count, bc: bus.bit_count};
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t got lk=%b ep=%b ll=%b ec=%0d bc=%0d need lk=%b ep=%b ll=%b ec=%0d bc=%0d",
                     $time, got.locked, got.err_pulse, got.lock_lost, got.ec, got.bc,
                     e.locked, e.err_pulse, e.lock_lost, e.ec, e.bc);
        end
        n_tests++;
        if (bus4.err_count !== sat4(m_ec) || bus4.bit_count !== sat4(m_bc)) begin
            n_fail++;
            $display("FAIL sat4_counters t=%0t got ec=%0d bc=%0d need ec=%0d bc=%0d",
                     $time, bus4.err_count, bus4.bit_count, sat4(m_ec), sat4(m_bc));
        end
        if (bus.lock_lost) lost_seen++;
    endtask

    task automatic check(input string name, input int got, input int need);
        n_tests++;
        if (got != need) begin
            n_fail++;
            $display("FAIL %s got %0d need %0d", name, got, need);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.clear = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_outputs", int'({bus.locked, bus.err_pulse, bus.lock_lost}), 0);
        check("reset_counts", int'(bus.err_count | bus.bit_count), 0);
        rst = 1'b0;
        lost_seen = 0;
        lfsr = SEED;
    endtask

    task automatic run_row(input row_t r, input bit do_rst);
        int idx = 0;
        int cyc = 0;
        logic b;
        if (do_rst) do_reset();
        while (idx < r.total) begin
            if (r.half && cyc[0]) begin
                step(1'b0, 1'($urandom), 1'b0);
            end else begin
                b = r.zero ? 1'b0 : (gen_bit() ^ is_err(r, idx));
                step(1'b1, b, 1'b0);
                idx++;
                if (r.chk_lock && (idx == 2 * VL - 1 || idx == 2 * VL))
                    check({r.name, "_lock_edge"}, int'(bus.locked), int'(idx == 2 * VL));
            end
            cyc++;
        end
    endtask

    row_t tbl[9];
    row_t rv;

    initial begin
        bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.clear = 1'b0;
        //             name       total  start n_per gap per half zero chk err lk lost
        tbl[0] = '{"clean",   10000,    0,    0,  1, 0, 0, 0, 1,  0, 1, 0};
        tbl[1] = '{"single",   1500,  500,    1,  1, 1, 0, 0, 1,  1, 1, 0};
        tbl[2] = '{"burst8",    800,  300,    8, 10, 1, 0, 0, 1,  8, 1, 1};
        tbl[3] = '{"seven4",   1300,  131,    7, 30, 4, 0, 0, 1, 28, 1, 0};
        tbl[4] = '{"seven4h",  1300,  131,    7, 30, 4, 1, 0, 1, 28, 1, 0};
        tbl[5] = '{"edge7p1",   900,  377,    8,  1, 1, 0, 0, 1,  8, 1, 0};
        tbl[6] = '{"edge8",    1000,  376,    8,  1, 1, 0, 0, 1,  8, 1, 1};
        tbl[7] = '{"zeros",    1000,    0,    0,  1, 0, 0, 1, 0,  0, 0, 0};
        tbl[8] = '{"vmiss",     400,  100,    1,  1, 1, 0, 0, 0,  0, 1, 0};

        for (int i = 0; i < 9; i++) begin
            run_row(tbl[i], 1'b1);
            check({tbl[i].name, "_err_count"}, int'(bus.err_count), tbl[i].exp_err);
            check({tbl[i].name, "_locked"}, int'(bus.locked), int'(tbl[i].exp_locked));
            check({tbl[i].name, "_lock_lost"}, lost_seen, tbl[i].exp_lost);
        end

        // clear while locked: counters zero next cycle, lock retained, counting resumes
        run_row(tbl[1], 1'b1);
        check("pre_clear_err", int'(bus.err_count), 1);
        step(1'b1, gen_bit(), 1'b1);
        check("clear_err", int'(bus.err_count), 0);
        check("clear_bits", int'(bus.bit_count), 0);
        check("clear_locked", int'(bus.locked), 1);
        for (int k = 0; k < 50; k++) step(1'b1, gen_bit(), 1'b0);
        check("post_clear_bits", int'(bus.bit_count), 50);

        // asynchronous reset while in VERIFY after a lost lock
        rv = '{"to_verify", 371 + VL + 10, 300, 8, 10, 1, 0, 0, 0, 8, 0, 1};
        run_row(rv, 1'b1);
        check("pre_rst_err", int'(bus.err_count), 8);
        check("pre_rst_locked", int'(bus.locked), 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_err", int'(bus.err_count), 0);
        check("async_rst_bits", int'(bus.bit_count), 0);
        check("async_rst_flags", int'({bus.locked, bus.err_pulse, bus.lock_lost}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
